// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer: oversampling edge/bit timer for the UART receiver with runtime frame config.
// Define UART_RX_GLITCH_CHECK_EN to abort the frame when the start bit samples high.
module uart_rx_frame_timer #(
    parameter int PRESCALE_WIDTH     = 6,
    parameter int EDGE_COUNTER_WIDTH = 5,
    parameter int BIT_COUNTER_WIDTH  = 4,
    parameter int MAX_DATA_WIDTH     = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    input  logic [3:0]                    data_len,
    input  logic                          par_en,
    input  logic                          stop2,
    input  logic                          count_enable,
    input  logic                          sampled_bit,
    output logic [EDGE_COUNTER_WIDTH-1:0] edge_cnt,
    output logic [BIT_COUNTER_WIDTH-1:0]  bit_cnt,
    output logic [1:0]                    frame_field,
    output logic                          sample_enable,
    output logic                          sample_point,
    output logic                          bit_done,
    output logic                          frame_done,
    output logic                          cfg_err,
    output logic                          start_glitch
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, state_nx;
    logic [PRESCALE_WIDTH-1:0] p_q, half, e;
    logic [3:0] dl_q;
    logic pe_q, s2_q, run, cfg_ok;
    logic [BIT_COUNTER_WIDTH-1:0] last_idx, dl_b;
    assign cfg_ok = (prescale == PRESCALE_WIDTH'(4) || prescale == PRESCALE_WIDTH'(8) ||
                     prescale == PRESCALE_WIDTH'(16) || prescale == PRESCALE_WIDTH'(32)) &&
                    data_len >= 4'd5 && data_len <= 4'(MAX_DATA_WIDTH);
    assign run = state == RUN && count_enable;
    assign e = PRESCALE_WIDTH'(edge_cnt);
    assign half = p_q >> 1;
    assign dl_b = BIT_COUNTER_WIDTH'(dl_q);
    // index of the final stop bit: data + optional parity + one or two stops
    assign last_idx = dl_b + BIT_COUNTER_WIDTH'(pe_q) + BIT_COUNTER_WIDTH'(s2_q) + BIT_COUNTER_WIDTH'(1);
    assign bit_done = run && e == p_q - 1'b1;
    assign frame_done = bit_done && bit_cnt == last_idx;
    assign sample_enable = run && e + PRESCALE_WIDTH'(2) >= half && e <= half;
    assign sample_point = run && e == half + 1'b1;
    assign frame_field = !run || bit_cnt == '0 ? 2'd0 :
                         bit_cnt <= dl_b ? 2'd1 :
                         pe_q && bit_cnt == dl_b + 1'b1 ? 2'd2 : 2'd3;
`ifdef UART_RX_GLITCH_CHECK_EN
    assign start_glitch = sample_point && bit_cnt == '0 && sampled_bit;
`else
    logic unused_sampled_bit;
    assign unused_sampled_bit = sampled_bit;
    assign start_glitch = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (count_enable) state_nx = cfg_ok ? RUN : HOLD;
            RUN: if (!count_enable || frame_done) state_nx = IDLE;
                 else if (start_glitch) state_nx = HOLD;
            default: if (!count_enable) state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            p_q      <= PRESCALE_WIDTH'(16);
            dl_q     <= '0;
            pe_q     <= 1'b0;
            s2_q     <= 1'b0;
            cfg_err  <= 1'b0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && count_enable) begin
                p_q     <= prescale;
                dl_q    <= data_len;
                pe_q    <= par_en;
                s2_q    <= stop2;
                cfg_err <= !cfg_ok;
            end else if (!count_enable) begin
                cfg_err <= 1'b0;
            end
            if (state == RUN && state_nx == RUN) begin
                edge_cnt <= bit_done ? '0 : edge_cnt + 1'b1;
                bit_cnt  <= bit_done ? bit_cnt + 1'b1 : bit_cnt;
            end else begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// tb_uart_rx_frame_timer: directed bench comparing the timer against an elapsed-time frame model.
module tb_uart_rx_frame_timer;
    logic clk = 0, rst = 1;
    logic [5:0] prescale = 16;
    logic [3:0] data_len = 8;
    logic par_en = 0, stop2 = 0, count_enable = 0, sampled_bit = 0;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [1:0] frame_field;
    logic sample_enable, sample_point, bit_done, frame_done, cfg_err, start_glitch;
    int checks = 0, errors = 0;
`ifdef UART_RX_GLITCH_CHECK_EN
    localparam bit GL = 1'b1;
`else
    localparam bit GL = 1'b0;
`endif

    uart_rx_frame_timer dut (
        .clk(clk), .rst(rst), .prescale(prescale), .data_len(data_len), .par_en(par_en),
        .stop2(stop2), .count_enable(count_enable), .sampled_bit(sampled_bit),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .frame_field(frame_field),
        .sample_enable(sample_enable), .sample_point(sample_point), .bit_done(bit_done),
        .frame_done(frame_done), .cfg_err(cfg_err), .start_glitch(start_glitch)
    );

    always #5 clk = ~clk;

    // model: mode 0 idle, 1 counting, 2 parked; m_t = cycles elapsed since counting began
    int m_mode = 0, m_t = 0, m_p = 16, m_dl = 0, m_pe = 0, m_s2 = 0;
    bit m_err = 0;

    function automatic bit exp_run(); return m_mode == 1 && count_enable; endfunction
    function automatic int exp_edge(); return m_mode == 1 ? m_t % m_p : 0; endfunction
    function automatic int exp_bit(); return m_mode == 1 ? m_t / m_p : 0; endfunction
    function automatic bit exp_bd(); return exp_run() && exp_edge() == m_p - 1; endfunction
    function automatic bit exp_fd();
        return exp_bd() && exp_bit() == m_dl + m_pe + 1 + m_s2;
    endfunction
    function automatic bit exp_se();
        return exp_run() && exp_edge() >= m_p / 2 - 2 && exp_edge() <= m_p / 2;
    endfunction
    function automatic bit exp_sp(); return exp_run() && exp_edge() == m_p / 2 + 1; endfunction
    function automatic int exp_field();
        int b = exp_bit();
        if (!exp_run() || b == 0) return 0;
        if (b <= m_dl) return 1;
        if (m_pe == 1 && b == m_dl + 1) return 2;
        return 3;
    endfunction
    function automatic bit exp_gl(); return GL && exp_sp() && exp_bit() == 0 && sampled_bit; endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_t <= 0; m_p <= 16; m_dl <= 0; m_pe <= 0; m_s2 <= 0; m_err <= 0;
        end else if (m_mode == 0) begin
            if (count_enable) begin
                m_p <= prescale; m_dl <= data_len; m_pe <= par_en; m_s2 <= stop2; m_t <= 0;
                if ((prescale inside {6'd4, 6'd8, 6'd16, 6'd32}) && data_len >= 5 && data_len <= 9)
                    m_mode <= 1;
                else begin
                    m_mode <= 2; m_err <= 1;
                end
            end
        end else if (m_mode == 1) begin
            if (!count_enable || exp_fd()) begin
                m_mode <= 0; m_t <= 0;
            end else if (exp_gl()) begin
                m_mode <= 2; m_t <= 0;
            end else m_t <= m_t + 1;
        end else if (!count_enable) begin
            m_mode <= 0; m_err <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        chk("edge_cnt", 32'(edge_cnt), exp_edge());
        chk("bit_cnt", 32'(bit_cnt), exp_bit());
        chk("frame_field", 32'(frame_field), exp_field());
        chk("sample_enable", 32'(sample_enable), 32'(exp_se()));
        chk("sample_point", 32'(sample_point), 32'(exp_sp()));
        chk("bit_done", 32'(bit_done), 32'(exp_bd()));
        chk("frame_done", 32'(frame_done), 32'(exp_fd()));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("start_glitch", 32'(start_glitch), 32'(exp_gl()));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fd(input int budget, output int n, output int bd, output int se);
        n = 0; bd = 0; se = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            bd += int'(bit_done);
            se += int'(sample_enable);
            if (frame_done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, bd, se;
        int fld[11];
        int want[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 2, 3, 3};
        #12;
        chk("rst_edge", 32'(edge_cnt), 0);
        chk("rst_bit", 32'(bit_cnt), 0);
        chk("rst_pulses", {26'd0, sample_enable, sample_point, bit_done, frame_done, cfg_err, start_glitch}, 0);
        @(posedge clk); #2 rst = 0;

        // 16x, 8N1
        count_enable = 1; tick(1);
        wait_fd(200, n, bd, se);
        chk("t1_frame_cycles", n, 160);
        chk("t1_last_bit", 32'(bit_cnt), 9);
        chk("t1_bit_dones", bd, 10);
        chk("t1_sample_en", se, 30);
        @(posedge clk); #2 count_enable = 0; tick(1);

        // 8x, 7 data, parity, 2 stops
        prescale = 8; data_len = 7; par_en = 1; stop2 = 1; count_enable = 1; tick(1);
        foreach (fld[i]) fld[i] = -1;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (edge_cnt == 0 && bit_cnt < 11) fld[bit_cnt] = int'(frame_field);
            if (frame_done) begin n = i; break; end
        end
        chk("t2_frame_cycles", n, 88);
        foreach (want[i]) chk($sformatf("t2_field[%0d]", i), fld[i], want[i]);
        @(posedge clk); #2 count_enable = 0; tick(1);

        // illegal configs
        prescale = 5; data_len = 8; par_en = 0; stop2 = 0; count_enable = 1; tick(4);
        chk("t3_err_p5", 32'(cfg_err), 1);
        chk("t3_edge_p5", 32'(edge_cnt), 0);
        count_enable = 0; tick(1);
        chk("t3_err_clr", 32'(cfg_err), 0);
        prescale = 16; data_len = 10; count_enable = 1; tick(4);
        chk("t3_err_dl10", 32'(cfg_err), 1);
        count_enable = 0; tick(1);
        chk("t3_err_clr2", 32'(cfg_err), 0);

        // abort by count_enable, then by reset
        data_len = 8; count_enable = 1; tick(1); tick(67);
        chk("t4_edge", 32'(edge_cnt), 3);
        chk("t4_bit", 32'(bit_cnt), 4);
        count_enable = 0; tick(1);
        chk("t4_edge_clr", 32'(edge_cnt), 0);
        chk("t4_bit_clr", 32'(bit_cnt), 0);
        count_enable = 1; tick(1); tick(23);
        chk("t4_se_before", 32'(sample_enable), 1);
        #1 rst = 1;
        #1;
        chk("t4_rst_edge", 32'(edge_cnt), 0);
        chk("t4_rst_bit", 32'(bit_cnt), 0);
        chk("t4_rst_se", 32'(sample_enable), 0);
        count_enable = 0;
        @(posedge clk); #2 rst = 0; tick(1);

        // back-to-back frames, prescale change mid-frame only applies to the next frame
        prescale = 4; data_len = 5; count_enable = 1; tick(1);
        prescale = 32;
        wait_fd(100, n, bd, se);
        chk("t5_frame1_cycles", n, 28);
        wait_fd(400, n, bd, se);
        chk("t5_frame2_cycles", n, 225);
        chk("t5_frame2_bd", bd, 7);
        @(posedge clk); #2 count_enable = 0; tick(1);

        // high start bit at the vote strobe
        prescale = 16; data_len = 8; sampled_bit = 1; count_enable = 1; tick(1); tick(9);
        chk("t6_sp", 32'(sample_point), 1);
        chk("t6_glitch", 32'(start_glitch), 32'(GL));
        tick(1);
        chk("t6_edge", 32'(edge_cnt), GL ? 0 : 10);
        tick(5);
        chk("t6_bd15", 32'(bit_done), GL ? 0 : 1);
        count_enable = 0; sampled_bit = 0; tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
